uart_rx: RTL and testbench

//   UART receiver, 8N1 format: 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame geometry and FSM states.
package uart_pkg;

  // Data bits per 8N1 frame.
  localparam int DATA_BITS = 8;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into clk.
// Flops reset to 1 so an idle-high serial line does not look like a start bit.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two-stage capture of each bit; the first stage may go metastable.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples the synchronized line with clk, samples each
// bit at its midpoint, and presents each good byte with a one-cycle done strobe.
module uart_rx #(
  parameter logic [13:0] KBAUD = 14'd10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_IN,
  output logic [7:0] data_OUT,
  output logic       Rx_done,
  output logic       busy
);

  import uart_pkg::*;

  localparam int KB = int'(KBAUD);
  localparam int CW = $clog2(KB);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(KB / 2 - 1);
  localparam logic [CW-1:0] TERM     = CW'(KB - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic                 rx_s;
  state_e               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [IW-1:0]        idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [7:0]           data_reg, data_next;
  logic                 done_reg, done_next;
  logic                 bit_tick;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (data_IN),
    .q   (rx_s)
  );

  // A data bit is captured at the terminal count of its bit period.
  assign bit_tick = (state_reg == DATA) && (cnt_reg == TERM);

  // Next-state, bit-timing counter and output load logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        // Half a bit in: confirm the start bit, otherwise treat it as a glitch.
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == TERM) begin
          cnt_next = '0;
          if (idx_reg == LAST_IDX) state_next = STOP;
          else                     idx_next   = idx_reg + 1'b1;
        end
      end
      STOP: begin
        // Deliver at mid-stop-bit so a back-to-back start edge is not missed.
        if (cnt_reg == TERM) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Framing error or break: wait for the line to return high.
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      data_reg  <= 8'h00;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

  // Each shift-register bit loads only when its own index is being sampled.
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst)                                  shift_reg[gi] <= 1'b0;
        else if (bit_tick && idx_reg == IW'(gi))  shift_reg[gi] <= rx_s;
      end
    end
  endgenerate

  assign data_OUT = data_reg;
  assign Rx_done  = done_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with KBAUD=16: vector table of frames plus
// hand-written sequences for reset, byte sweep, glitch and mid-frame reset.
module tb_uart_rx;

  localparam logic [13:0] KB   = 14'd16;
  localparam int          BITW = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_IN = 1'b1;
  logic [7:0] data_OUT;
  logic       Rx_done;
  logic       busy;

  uart_rx #(.KBAUD(KB)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_IN  (data_IN),
    .data_OUT (data_OUT),
    .Rx_done  (Rx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int hold_viol = 0;
  logic [7:0] prev_data = 8'h00;
  logic       rst_last = 1'b1;
  logic [7:0] rx_q[$];
  logic       bq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every done pulse and flag data_OUT changes not accompanied by one.
  always @(negedge clk) begin
    if (Rx_done === 1'b1) begin
      rx_q.push_back(data_OUT);
      bq.push_back(busy);
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (!rst && !rst_last && Rx_done !== 1'b1 && data_OUT !== prev_data)
      hold_viol <= hold_viol + 1;
    prev_data <= data_OUT;
    rst_last  <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    data_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    data_IN = v;
    repeat (BITW) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic chk_busy);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (chk_busy && i == 3) chk("busy_mid_frame", 32'(busy), 32'd1);
    end
    send_bit(stop_v);
    data_IN = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    int         exp_pulses;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n0, q0, st;
    logic [7:0] d0;
    logic seen;

    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 1, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF};
    vecs[5] = '{8'h01, 1'b0, 0, 8'hFF};

    // Reset, then a long idle line.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(data_OUT), 32'h00);
    chk("reset_done", 32'(Rx_done), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(100);
    chk("idle_data", 32'(data_OUT), 32'h00);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pulses", 32'(done_cnt), 32'd0);
    $display("reset/idle done");

    // Vector table: one frame each with an idle gap after it.
    for (int v = 0; v < 6; v++) begin
      n0 = done_cnt;
      st = cyc;
      send_frame(vecs[v].data, vecs[v].stop_v, 1'b1);
      idle(24);
      $display("vec %0d byte=%02h stop=%0b pulses=%0d data_OUT=%02h",
               v, vecs[v].data, vecs[v].stop_v, done_cnt - n0, data_OUT);
      chk("vec_pulses", 32'(done_cnt - n0), 32'(vecs[v].exp_pulses));
      chk("vec_data", 32'(data_OUT), 32'(vecs[v].exp_data));
      chk("vec_busy_after", 32'(busy), 32'd0);
      if (vecs[v].exp_pulses == 1) begin
        chk("vec_busy_at_done", 32'(bq[bq.size()-1]), 32'd0);
        chk("vec_data_at_done", 32'(rx_q[rx_q.size()-1]), 32'(vecs[v].exp_data));
      end
      if (v == 0) begin
        // 2 + HALF + 9*KBAUD = 154 cycles from the start edge, allow small slack.
        chk("latency_low", 32'(last_done_cyc - st >= 152), 32'd1);
        chk("latency_high", 32'(last_done_cyc - st <= 156), 32'd1);
      end
    end

    // Short low glitch on an idle line.
    d0 = data_OUT;
    n0 = done_cnt;
    data_IN = 1'b0;
    repeat (3) @(negedge clk);
    data_IN = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    idle(20);
    $display("glitch busy_seen=%0b pulses=%0d data_OUT=%02h", seen, done_cnt - n0, data_OUT);
    chk("glitch_busy_seen", 32'(seen), 32'd1);
    chk("glitch_pulses", 32'(done_cnt - n0), 32'd0);
    chk("glitch_data", 32'(data_OUT), 32'(d0));
    chk("glitch_busy_after", 32'(busy), 32'd0);

    // Back-to-back sweep of every byte value.
    n0 = done_cnt;
    q0 = rx_q.size();
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1, 1'b0);
    idle(40);
    chk("sweep_pulses", 32'(done_cnt - n0), 32'd256);
    for (int b = 0; b < 256 && (q0 + b) < rx_q.size(); b++) begin
      $display("sweep byte=%02h got=%02h busy=%0b", b[7:0], rx_q[q0+b], bq[q0+b]);
      chk("sweep_data", 32'(rx_q[q0+b]), 32'(b));
      chk("sweep_busy_at_done", 32'(bq[q0+b]), 32'd0);
    end

    // Reset in the middle of data bit 4 of 8'hFF.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    data_IN = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("midframe reset data_OUT=%02h busy=%0b done=%0b", data_OUT, busy, Rx_done);
    chk("mid_rst_data", 32'(data_OUT), 32'h00);
    chk("mid_rst_done", 32'(Rx_done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    n0 = done_cnt;
    idle(100);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_data", 32'(data_OUT), 32'h00);
    chk("post_rst_pulses", 32'(done_cnt - n0), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(24);
    $display("after reset byte=5a pulses=%0d data_OUT=%02h", done_cnt - n0, data_OUT);
    chk("post_rst_frame_pulses", 32'(done_cnt - n0), 32'd1);
    chk("post_rst_frame_data", 32'(data_OUT), 32'h5A);

    chk("data_hold_violations", 32'(hold_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
